sram_controller: RTL
====================

Name: sram_controller

Overview:
- Multi-cycle responder for the MEM-stage data-memory requests (mem_r_en / mem_w_en, ALU address, val_rm store data) that the pipeline registers carry forward from decode.
- Maps a 32-bit word access onto an external 16-bit asynchronous SRAM as two half-word phases.
- Holds ready low while busy; the hazard/freeze logic uses ~ready to stall every pipeline register.

Parameters:
- BASE_ADDR, 1024: byte address of data-memory word 0.
- ACCESS_CYCLES, 3: cycles per half-word phase; legal range is 2 to 15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- rd_en  in  1  load request (mem_r_en), held by the pipeline until ready.
- wr_en  in  1  store request (mem_w_en), held by the pipeline until ready.
- address  in  32  byte address from the ALU.
- write_data  in  32  store data (val_rm).
- read_data  out  32  load result.
- ready  out  1  high when there is no outstanding request or the access completes this cycle.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to the pad.
- sram_dq_oe  out  1  drive enable for sram_dq_out.
- sram_dq_in  in  16  read data from the pad.
- sram_we_n  out  1  write strobe, active-low.

Behaviour:
- Reset: asynchronous and active-high.
  - State goes to IDLE immediately, including when reset hits mid-operation; the access is aborted with no completion.
  - read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Address mapping:
  - idx = (address - BASE_ADDR) >> 2, modulo 2^32; out-of-range addresses wrap, no error.
  - Low phase: sram_addr = {idx[SRAM_AW-2:0], 1'b0}. High phase: same with LSB = 1.
- States: IDLE, LOW, HIGH, DONE. A phase counter cnt counts 1..ACCESS_CYCLES in LOW and HIGH.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational.
  - On rd_en|wr_en: latch idx, write_data and op, then go to LOW with cnt=1.
  - If rd_en and wr_en are both high, treat it as a read; no SRAM write occurs.
- LOW / HIGH:
  - ready=0.
  - sram_addr is held for the whole phase.
  - Write op:
    - sram_dq_oe=1 for the whole phase.
    - sram_dq_out = data[15:0] in LOW, data[31:16] in HIGH.
    - sram_we_n=0 for cnt 1..ACCESS_CYCLES-1 and 1 at cnt=ACCESS_CYCLES, giving a data-hold cycle.
  - Read op:
    - sram_dq_oe=0, sram_we_n=1.
    - At the edge ending cnt=ACCESS_CYCLES, capture sram_dq_in into read_data[15:0] (LOW) or read_data[31:16] (HIGH).
  - LOW goes to HIGH, and HIGH goes to DONE, when cnt=ACCESS_CYCLES.
- DONE:
  - ready=1 for exactly one cycle; the pipeline advances on this edge.
  - read_data holds the full word; next state is IDLE.
- read_data holds its value until the next read overwrites it. Writes never change read_data.
- Latency: a request first seen in cycle 0 gets ready=1 in cycle 2*ACCESS_CYCLES+1 (cycle 7 at the default).
- New requests are sampled only in IDLE. A request still high after DONE is treated as a new access.
- Request deassertion mid-access is ignored; the access completes.
- Changes to address and write_data after acceptance are ignored (latched values are used).

Test Plan:
- Reset: assert rst in mid-HIGH of a write -> sram_we_n=1, sram_dq_oe=0 and read_data=0 immediately; ready=1 with no request; SRAM contents at the high half are unchanged.
- Store: wr_en with address=1032, write_data=0xDEADBEEF -> sram_addr=4 with dq_out=0xBEEF, then sram_addr=5 with dq_out=0xDEAD. Each phase has we_n low for 2 cycles, then high for 1. ready=0 in cycles 0-6 and 1 in cycle 7.
- Load: rd_en at address=1032 against the model from the store test -> read_data=0xDEADBEEF in DONE (cycle 7); sram_dq_oe=0 throughout.
- Back-to-back: a store to address 1024 followed immediately by a load from 1024 -> the second access starts in the cycle after DONE and returns the stored word.
- Both enables: rd_en=wr_en=1 at address 1028 -> no we_n pulse; the read value is returned.
- Wrap: address=0 -> idx=0x3FFFFF00, sram_addr low phase = 0x3FE00 (low 17 bits of idx, then 0); completes normally.

Source files
------------

// File: rtl/sram_controller.sv
// Data-memory responder: one 32-bit load/store becomes two half-word phases on
// an asynchronous 16-bit SRAM. ready stays low while an access is in flight.
module sram_controller #(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 3,
    parameter int SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [3:0]         r_cnt;
    logic [SRAM_AW-2:0] r_idx;
    logic [31:0]        r_data;
    logic               r_wr;
    logic [31:0]        r_rd_data;

    logic [31:0]        w_off;
    logic               w_req, w_last, w_phase, w_high;
    logic               w_unused;

    // Word index is (address - BASE_ADDR) >> 2; only the bits that reach the pad are kept.
    assign w_off    = address - 32'(BASE_ADDR);
    assign w_unused = ^{w_off[31:SRAM_AW+1], w_off[1:0]};
    assign w_req    = rd_en | wr_en;
    assign w_last   = (r_cnt == 4'(ACCESS_CYCLES));
    assign w_high   = (r_state == S_HIGH);
    assign w_phase  = (r_state == S_LOW) | w_high;

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = ~w_req;
                if (w_req) w_next = S_LOW;
            end
            S_LOW:  if (w_last) w_next = S_HIGH;
            S_HIGH: if (w_last) w_next = S_DONE;
            S_DONE: begin
                ready  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Pad signals decode straight from registered state, so reset clears them at once.
    assign sram_addr   = w_phase ? {r_idx, w_high} : '0;
    assign sram_dq_oe  = w_phase & r_wr;
    assign sram_dq_out = sram_dq_oe ? (w_high ? r_data[31:16] : r_data[15:0]) : 16'h0;
    // Strobe releases on the last cycle of each phase so data is held past we_n rising.
    assign sram_we_n   = ~(sram_dq_oe & ~w_last);
    assign read_data   = r_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_data    <= 32'h0;
            r_wr      <= 1'b0;
            r_rd_data <= 32'h0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx  <= w_off[SRAM_AW:2];
                        r_data <= write_data;
                        r_wr   <= wr_en & ~rd_en;
                        r_cnt  <= 4'd1;
                    end
                end
                S_LOW, S_HIGH: begin
                    r_cnt <= w_last ? 4'd1 : r_cnt + 4'd1;
                    if (w_last && !r_wr) begin
                        if (w_high) r_rd_data[31:16] <= sram_dq_in;
                        else        r_rd_data[15:0]  <= sram_dq_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
